// File: rtl/fetch_decode_stage_if.sv
// Fetch/decode stage bus: hazard and branch controls, instruction memory port,
// and the registered ID outputs.
interface fetch_decode_stage_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic [4:0]  opcode_d;
    logic [26:0] imm_field_d;
    logic [1:0]  imm_src_d;
    logic [31:0] instr_count;

    modport master (
        input  stall, flush, branch_taken, branch_target, imem_data,
        output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
               opcode_d, imm_field_d, imm_src_d, instr_count
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, imem_data,
        input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
               opcode_d, imm_field_d, imm_src_d, instr_count
    );
endinterface

// File: rtl/fetch_decode_stage.sv
// Fetch PC register and IF/ID pipeline register with immediate-format
// pre-decode and a count of valid instructions captured into ID.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_decode_stage_if.master    fd
);
    typedef enum logic [1:0] {
        IMM_DP   = 2'b00,
        IMM_MEM  = 2'b01,
        IMM_BR   = 2'b10,
        IMM_JUMP = 2'b11
    } imm_src_e;

    logic [31:0] pc_f;
    logic [31:0] pc_f_plus4;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    imm_src_e    imm_src_q;
    imm_src_e    imm_src_next;
    logic [31:0] count_q;

    assign pc_f_plus4 = pc_f + 32'd4;

    always_comb begin
        imm_src_next = IMM_DP;
        case (fd.imem_data[31:30])
            2'b00: imm_src_next = IMM_DP;
            2'b01: imm_src_next = IMM_MEM;
            2'b10: imm_src_next = IMM_BR;
            2'b11: imm_src_next = IMM_JUMP;
            default: imm_src_next = IMM_DP;
        endcase
    end

    // Priority: rst > branch_taken > flush > stall > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            imm_src_q  <= IMM_DP;
            count_q    <= '0;
        end else if (fd.branch_taken) begin
            pc_f       <= fd.branch_target;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            imm_src_q  <= IMM_DP;
        end else if (fd.flush) begin
            if (!fd.stall) begin
                pc_f <= pc_f_plus4;
            end
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            imm_src_q  <= IMM_DP;
        end else if (!fd.stall) begin
            pc_f       <= pc_f_plus4;
            instr_q    <= fd.imem_data;
            pc_q       <= pc_f;
            pc_plus4_q <= pc_f_plus4;
            valid_q    <= 1'b1;
            imm_src_q  <= imm_src_next;
            count_q    <= count_q + 32'd1;
        end
    end

    assign fd.imem_addr   = pc_f;
    assign fd.instr_d     = instr_q;
    assign fd.pc_d        = pc_q;
    assign fd.pc_plus4_d  = pc_plus4_q;
    assign fd.valid_d     = valid_q;
    assign fd.imm_src_d   = imm_src_q;
    assign fd.instr_count = count_q;
    assign fd.opcode_d    = instr_q[31:27];
    assign fd.imm_field_d = instr_q[26:0];
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: sequential fetch, stall, branch,
// flush, PC wrap-around and reset priority.
module tb_fetch_decode_stage;
    localparam logic [31:0] NOP = 32'hDEAD_0013;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fetch_decode_stage_if fd ();

    fetch_decode_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fd  (fd)
    );

    always #5 clk = ~clk;

    // Asynchronous instruction memory: three fixed words, otherwise the address itself.
    always_comb begin
        case (fd.imem_addr)
            32'h0000_0000: fd.imem_data = 32'h0800_0001;
            32'h0000_0004: fd.imem_data = 32'h4800_0002;
            32'h0000_0008: fd.imem_data = 32'h8800_0003;
            default:       fd.imem_data = fd.imem_addr;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic b, input logic [31:0] t,
                         input logic f, input logic s);
        rst = r; fd.branch_taken = b; fd.branch_target = t; fd.flush = f; fd.stall = s;
    endtask

    task automatic test_reset();
        drive(1, 0, '0, 0, 0);
        step();
        checks++; if (fd.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h exp %h", fd.imem_addr, 32'h0); end
        checks++; if (fd.instr_d !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", fd.instr_d, NOP); end
        checks++; if (fd.valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fd.valid_d); end
        checks++; if (fd.pc_d !== 32'h0 || fd.pc_plus4_d !== 32'h0) begin errors++; $display("FAIL reset_pc got %h/%h exp 0/0", fd.pc_d, fd.pc_plus4_d); end
        checks++; if (fd.imm_src_d !== 2'b00) begin errors++; $display("FAIL reset_imm_src got %b exp 00", fd.imm_src_d); end
        checks++; if (fd.instr_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fd.instr_count); end
        drive(0, 0, '0, 0, 0);
    endtask

    task automatic test_sequential();
        step();
        checks++; if (fd.instr_d !== 32'h0800_0001 || fd.valid_d !== 1'b1) begin errors++; $display("FAIL seq0_instr got %h v%b exp 08000001 v1", fd.instr_d, fd.valid_d); end
        checks++; if (fd.pc_d !== 32'h0 || fd.pc_plus4_d !== 32'h4 || fd.imm_src_d !== 2'b00) begin errors++; $display("FAIL seq0_pc got %h %h %b exp 0 4 00", fd.pc_d, fd.pc_plus4_d, fd.imm_src_d); end
        step();
        checks++; if (fd.pc_d !== 32'h4 || fd.imm_src_d !== 2'b01) begin errors++; $display("FAIL seq1 got %h %b exp 4 01", fd.pc_d, fd.imm_src_d); end
        step();
        checks++; if (fd.pc_d !== 32'h8 || fd.imm_src_d !== 2'b10) begin errors++; $display("FAIL seq2 got %h %b exp 8 10", fd.pc_d, fd.imm_src_d); end
        checks++; if (fd.opcode_d !== 5'b10001 || fd.imm_field_d !== 27'h000_0003) begin errors++; $display("FAIL seq2_slices got %b %h exp 10001 0000003", fd.opcode_d, fd.imm_field_d); end
        checks++; if (fd.instr_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", fd.instr_count); end
        checks++; if (fd.imem_addr !== 32'hC) begin errors++; $display("FAIL seq_imem_addr got %h exp c", fd.imem_addr); end
    endtask

    task automatic test_stall();
        test_reset();
        step();
        step();
        checks++; if (fd.instr_d !== 32'h4800_0002 || fd.instr_count !== 32'd2) begin errors++; $display("FAIL stall_pre got %h %0d exp 48000002 2", fd.instr_d, fd.instr_count); end
        drive(0, 0, '0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (fd.instr_d !== 32'h4800_0002 || fd.pc_d !== 32'h4 || fd.valid_d !== 1'b1) begin errors++; $display("FAIL stall_hold_id%0d got %h %h v%b exp 48000002 4 v1", i, fd.instr_d, fd.pc_d, fd.valid_d); end
            checks++; if (fd.imem_addr !== 32'h8 || fd.instr_count !== 32'd2) begin errors++; $display("FAIL stall_hold_pc%0d got %h %0d exp 8 2", i, fd.imem_addr, fd.instr_count); end
        end
        drive(0, 0, '0, 0, 0);
        step();
        checks++; if (fd.instr_d !== 32'h8800_0003 || fd.pc_d !== 32'h8 || fd.instr_count !== 32'd3 || fd.imem_addr !== 32'hC) begin errors++; $display("FAIL stall_resume got %h %h %0d %h exp 88000003 8 3 c", fd.instr_d, fd.pc_d, fd.instr_count, fd.imem_addr); end
    endtask

    task automatic test_branch_stall();
        drive(0, 1, 32'h0000_0100, 0, 1);
        step();
        checks++; if (fd.imem_addr !== 32'h100) begin errors++; $display("FAIL br_imem_addr got %h exp 100", fd.imem_addr); end
        checks++; if (fd.valid_d !== 1'b0 || fd.instr_d !== NOP || fd.pc_d !== 32'h0 || fd.pc_plus4_d !== 32'h0) begin errors++; $display("FAIL br_bubble got v%b %h %h %h exp v0 %h 0 0", fd.valid_d, fd.instr_d, fd.pc_d, fd.pc_plus4_d, NOP); end
        checks++; if (fd.imm_src_d !== 2'b00 || fd.instr_count !== 32'd3) begin errors++; $display("FAIL br_imm_count got %b %0d exp 00 3", fd.imm_src_d, fd.instr_count); end
        drive(0, 0, '0, 0, 0);
        step();
        checks++; if (fd.pc_d !== 32'h100 || fd.pc_plus4_d !== 32'h104 || fd.instr_d !== 32'h100 || fd.valid_d !== 1'b1) begin errors++; $display("FAIL br_target got %h %h %h v%b exp 100 104 100 v1", fd.pc_d, fd.pc_plus4_d, fd.instr_d, fd.valid_d); end
        checks++; if (fd.instr_count !== 32'd4) begin errors++; $display("FAIL br_count got %0d exp 4", fd.instr_count); end
    endtask

    task automatic test_flush();
        drive(0, 0, '0, 1, 1);
        step();
        checks++; if (fd.valid_d !== 1'b0 || fd.imm_src_d !== 2'b00 || fd.instr_d !== NOP) begin errors++; $display("FAIL flst_bubble got v%b %b %h exp v0 00 %h", fd.valid_d, fd.imm_src_d, fd.instr_d, NOP); end
        checks++; if (fd.imem_addr !== 32'h104 || fd.instr_count !== 32'd4) begin errors++; $display("FAIL flst_hold got %h %0d exp 104 4", fd.imem_addr, fd.instr_count); end
        drive(0, 0, '0, 1, 0);
        step();
        checks++; if (fd.imem_addr !== 32'h108 || fd.valid_d !== 1'b0 || fd.instr_count !== 32'd4) begin errors++; $display("FAIL flush_adv got %h v%b %0d exp 108 v0 4", fd.imem_addr, fd.valid_d, fd.instr_count); end
        drive(0, 0, '0, 0, 0);
        step();
        checks++; if (fd.pc_d !== 32'h108 || fd.instr_count !== 32'd5) begin errors++; $display("FAIL flush_resume got %h %0d exp 108 5", fd.pc_d, fd.instr_count); end
    endtask

    task automatic test_wrap();
        drive(0, 1, 32'hFFFF_FFFC, 0, 0);
        step();
        checks++; if (fd.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_branch got %h exp fffffffc", fd.imem_addr); end
        drive(0, 0, '0, 0, 0);
        step();
        checks++; if (fd.pc_d !== 32'hFFFF_FFFC || fd.pc_plus4_d !== 32'h0 || fd.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h %h %h exp fffffffc 0 0", fd.pc_d, fd.pc_plus4_d, fd.imem_addr); end
        checks++; if (fd.imm_src_d !== 2'b11 || fd.opcode_d !== 5'b11111 || fd.imm_field_d !== 27'h7FF_FFFC) begin errors++; $display("FAIL wrap_decode got %b %b %h exp 11 11111 7fffffc", fd.imm_src_d, fd.opcode_d, fd.imm_field_d); end
        step();
        checks++; if (fd.instr_d !== 32'h0800_0001 || fd.pc_d !== 32'h0 || fd.instr_count !== 32'd7) begin errors++; $display("FAIL wrap_next got %h %h %0d exp 08000001 0 7", fd.instr_d, fd.pc_d, fd.instr_count); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 32'h0000_0200, 1, 1);
        step();
        checks++; if (fd.imem_addr !== 32'h0 || fd.valid_d !== 1'b0 || fd.instr_count !== 32'd0) begin errors++; $display("FAIL rstmid got %h v%b %0d exp 0 v0 0", fd.imem_addr, fd.valid_d, fd.instr_count); end
        checks++; if (fd.instr_d !== NOP || fd.pc_d !== 32'h0 || fd.imm_src_d !== 2'b00) begin errors++; $display("FAIL rstmid_id got %h %h %b exp %h 0 00", fd.instr_d, fd.pc_d, fd.imm_src_d, NOP); end
        drive(0, 0, '0, 0, 0);
        step();
        checks++; if (fd.instr_d !== 32'h0800_0001 || fd.valid_d !== 1'b1 || fd.instr_count !== 32'd1 || fd.imem_addr !== 32'h4) begin errors++; $display("FAIL rstmid_first got %h v%b %0d %h exp 08000001 v1 1 4", fd.instr_d, fd.valid_d, fd.instr_count, fd.imem_addr); end
    endtask

    initial begin
        drive(1, 0, '0, 0, 0);
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word inserted into the ID register on a bubble.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hazard unit: hold PC and the ID register.
REQ-006 flush  in  1  hazard unit: replace the ID register contents with a bubble.
REQ-007 branch_taken  in  1  execute stage: redirect fetch.
REQ-008 branch_target  in  32  redirect address, valid when branch_taken=1.
REQ-009 imem_addr  out  32  instruction memory address; equals the current fetch PC (pc_f), combinational.
REQ-010 imem_data  in  32  instruction word at imem_addr, same-cycle (asynchronous read).
REQ-011 instr_d  out  32  registered instruction in ID.
REQ-012 pc_d, pc_plus4_d  out  32 each  PC of instr_d, and that PC + 4.
REQ-013 valid_d  out  1  instr_d is a real instruction (0 means bubble).
REQ-014 opcode_d  out  5  instr_d[31:27].
REQ-015 imm_field_d  out  27  instr_d[26:0]; drives the sign extender's num_in.
REQ-016 imm_src_d  out  2  immediate-format select; drives the sign extender's imm_src.
REQ-017 instr_count  out  32  number of valid instructions captured into ID since reset.

Function
REQ-018 The PC register (pc_f) and the ID register (instr_d, pc_d, pc_plus4_d, valid_d, imm_src_d) SHALL update only on the rising edge of clk.
REQ-019 The per-edge priority SHALL be: rst > branch_taken > flush > stall > normal advance.
REQ-020 Normal advance (no rst, branch_taken, flush or stall):
- pc_f <= pc_f + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0);
- instr_d <= imem_data, pc_d <= pc_f, pc_plus4_d <= pc_f + 4, valid_d <= 1.
REQ-021 branch_taken=1, regardless of stall or flush:
- pc_f <= branch_target;
- the ID register takes a bubble: instr_d <= NOP_INSTR, valid_d <= 0, pc_d <= 0, pc_plus4_d <= 0.
REQ-022 flush=1 with branch_taken=0: the ID register takes a bubble; pc_f advances by 4 if stall=0 and holds if stall=1.
REQ-023 stall=1 with branch_taken=0 and flush=0: pc_f and the entire ID register SHALL hold their values.
REQ-024 imm_src_d SHALL be registered with instr_d, decoded from the captured instruction's bits [31:30]:
- 00 -> 2'b00 (data-processing, 12-bit immediate);
- 01 -> 2'b01 (memory, 16-bit);
- 10 -> 2'b10 (branch, 24-bit);
- 11 -> 2'b11 (jump, 27-bit).
REQ-025 On a bubble, imm_src_d SHALL be 2'b00.
REQ-026 opcode_d and imm_field_d SHALL be combinational slices of instr_d.
REQ-027 instr_count SHALL increment by 1 on every edge where valid_d is loaded with 1 (normal advance only), wrapping from 32'hFFFF_FFFF to 0; it SHALL hold otherwise.
REQ-028 The first instruction SHALL be fetched from RESET_PC; it appears on instr_d with valid_d=1 one edge after rst is deasserted.

Reset
REQ-029 With rst=1 at an edge, the block SHALL load:
- pc_f = RESET_PC;
- instr_d = NOP_INSTR, valid_d = 0, pc_d = 0, pc_plus4_d = 0;
- imm_src_d = 0, instr_count = 0.
REQ-030 Reset asserted mid-operation SHALL override stall, flush and branch_taken on the same edge; no partial update is permitted.

Verification
REQ-031 Sequential fetch: reset, then 3 edges with memory returning 32'h0800_0001, 32'h4800_0002 and 32'h8800_0003 at addresses 0, 4 and 8 -> pc_d = 0, 4, 8; imm_src_d = 00, 01, 10; instr_count = 3; imem_addr = 12.
REQ-032 Stall: assert stall for 2 edges while instr_d = 32'h4800_0002 -> instr_d, pc_d, imem_addr and instr_count unchanged; after release, advance resumes at the held PC.
REQ-033 Branch with stall: branch_taken=1, branch_target=32'h0000_0100, stall=1 -> next edge imem_addr = 32'h100, valid_d = 0, instr_d = NOP_INSTR; the following edge pc_d = 32'h100.
REQ-034 Flush plus stall: flush=1, stall=1 -> valid_d = 0, imm_src_d = 00, pc_f held, instr_count held.
REQ-035 Wrap-around: branch to 32'hFFFF_FFFC, then advance one edge -> pc_d = 32'hFFFF_FFFC, pc_plus4_d = 0, imem_addr = 0.
REQ-036 Reset mid-run: rst=1 together with branch_taken=1 and branch_target=32'h200 -> imem_addr = RESET_PC, valid_d = 0, instr_count = 0.
